vanilla_exe_bubble_classifier: RTL and testbench

Profiling-only companion block for the vanilla core pipeline.
- Each cycle it reports whether the EXE-stage slot holds a bubble, and if so why and which PC is blamed.
- A per-register shadow scoreboard remembers what kind of long-latency op owns each pending destination register. This lets long-op dependency stalls be attributed to DRAM, global, tile-group, AMO or divider traffic.
- Non-synthesised; consumed by the PC histogram and other profilers.

---
 rtl/vanilla_exe_bubble_classifier_pkg.sv | 96 +++++++++
 rtl/vanilla_bubble_scoreboard.sv | 48 ++++
 rtl/vanilla_exe_bubble_classifier.sv | 197 +++++++++++++++++++
 tb/tb_vanilla_exe_bubble_classifier.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vanilla_exe_bubble_classifier_pkg.sv
// Shared types for the EXE bubble classifier: bubble causes, long-op shadow classes
// and the slice of the pipeline-register structs this profiler looks at.
package vanilla_exe_bubble_classifier_pkg;

  localparam int RV32_reg_addr_width_gp = 5;
  localparam int RV32_Iimm_width_gp     = 12;

  typedef enum logic [4:0] {
    e_exe_no_bubble,
    e_exe_bubble_branch_miss,
    e_exe_bubble_jalr_miss,
    e_exe_bubble_icache_miss,
    e_exe_bubble_stall_depend_dram,
    e_exe_bubble_stall_depend_dram_amo,
    e_exe_bubble_stall_depend_global,
    e_exe_bubble_stall_depend_group,
    e_exe_bubble_stall_depend_group_amo,
    e_exe_bubble_stall_depend_group_overflow,
    e_exe_bubble_stall_depend_fdiv,
    e_exe_bubble_stall_depend_idiv,
    e_exe_bubble_stall_depend_local_load,
    e_exe_bubble_stall_depend_imul,
    e_exe_bubble_stall_amo_aq,
    e_exe_bubble_stall_amo_rl,
    e_exe_bubble_stall_bypass,
    e_exe_bubble_stall_lr_aq,
    e_exe_bubble_stall_fence,
    e_exe_bubble_stall_remote_req,
    e_exe_bubble_stall_remote_credit,
    e_exe_bubble_stall_fdiv_busy,
    e_exe_bubble_stall_idiv_busy,
    e_exe_bubble_stall_fcsr,
    e_exe_bubble_stall_barrier
  } exe_bubble_type_e;

  typedef enum logic [3:0] {
    e_sb_none,
    e_sb_dram,
    e_sb_dram_amo,
    e_sb_global,
    e_sb_group,
    e_sb_group_amo,
    e_sb_group_overflow,
    e_sb_idiv,
    e_sb_fdiv
  } sb_class_e;

  typedef struct packed {
    logic write_rd;
    logic write_frd;
    logic read_rs1;
    logic read_rs2;
    logic read_frs1;
    logic read_frs2;
    logic read_frs3;
    logic is_load_op;
    logic is_amo_op;
    logic is_idiv_op;
    logic is_fp_div_op;   // fdiv or fsqrt
  } decode_s;

  typedef struct packed {
    logic                              icache_miss;
    decode_s                           decode;
    logic [RV32_reg_addr_width_gp-1:0] rs1;
    logic [RV32_reg_addr_width_gp-1:0] rs2;
    logic [RV32_reg_addr_width_gp-1:0] rs3;
    logic [RV32_reg_addr_width_gp-1:0] rd;
  } id_signals_s;

  typedef struct packed {
    logic                              valid;
    logic [RV32_reg_addr_width_gp-1:0] rd;
  } exe_signals_s;

  typedef struct packed {
    logic [2:0] fp_rm;
    logic       fp_valid;
  } fp_exe_ctrl_signals_s;

  // An empty lookup means the producer was already retired from the shadow
  // table, so the stall is blamed on generic global traffic.
  function automatic exe_bubble_type_e class_to_bubble(sb_class_e c);
    case (c)
      e_sb_dram:           return e_exe_bubble_stall_depend_dram;
      e_sb_dram_amo:       return e_exe_bubble_stall_depend_dram_amo;
      e_sb_group:          return e_exe_bubble_stall_depend_group;
      e_sb_group_amo:      return e_exe_bubble_stall_depend_group_amo;
      e_sb_group_overflow: return e_exe_bubble_stall_depend_group_overflow;
      e_sb_idiv:           return e_exe_bubble_stall_depend_idiv;
      e_sb_fdiv:           return e_exe_bubble_stall_depend_fdiv;
      default:             return e_exe_bubble_stall_depend_global;
    endcase
  endfunction

endpackage

// File: rtl/vanilla_bubble_scoreboard.sv
// Shadow class table: remembers which kind of long-latency op owns each pending
// int and float destination register.
module vanilla_bubble_scoreboard
  import vanilla_exe_bubble_classifier_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       int_set,
  input  logic [4:0] int_set_id,
  input  sb_class_e  int_set_class,
  input  logic       fp_set,
  input  logic [4:0] fp_set_id,
  input  sb_class_e  fp_set_class,
  input  logic       int_clear,
  input  logic [4:0] int_clear_id,
  input  logic       fp_clear,
  input  logic [4:0] fp_clear_id,
  input  logic [4:0] int_read_id [3],
  output sb_class_e  int_read_class [3],
  input  logic [4:0] fp_read_id [4],
  output sb_class_e  fp_read_class [4]
);

  sb_class_e int_tbl [32];
  sb_class_e fp_tbl  [32];

  always_ff @(posedge clk_i) begin
    // NOTE: every entry is reset because "none" is meaningful state here, not don't-care data.
    if (reset_i) begin
      for (int i = 0; i < 32; i++) begin
        int_tbl[i] <= e_sb_none;
        fp_tbl[i]  <= e_sb_none;
      end
    end else begin
      // NOTE: non-blocking writes to one entry resolve to the last one, so set beats clear.
      if (int_clear)                     int_tbl[int_clear_id] <= e_sb_none;
      if (fp_clear)                      fp_tbl[fp_clear_id]   <= e_sb_none;
      if (int_set && int_set_id != 5'd0) int_tbl[int_set_id]   <= int_set_class;
      if (fp_set)                        fp_tbl[fp_set_id]     <= fp_set_class;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) int_read_class[i] = int_tbl[int_read_id[i]];
    for (int i = 0; i < 4; i++) fp_read_class[i]  = fp_tbl[fp_read_id[i]];
  end

endmodule

// File: rtl/vanilla_exe_bubble_classifier.sv
// Profiling companion for the vanilla core: each cycle reports whether the EXE slot
// is a bubble, why, and which PC to blame.
module vanilla_exe_bubble_classifier
  import vanilla_exe_bubble_classifier_pkg::*;
#(
  parameter int pc_width_p      = 32,
  parameter int data_width_p    = 32,
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 3,
  parameter int origin_x_cord_p = 0,
  parameter int origin_y_cord_p = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [pc_width_p-1:0]         pc_r,
  input  logic [pc_width_p-1:0]         pc_n,
  input  logic [data_width_p-1:0]       if_pc,
  input  logic [data_width_p-1:0]       id_pc,
  input  logic [data_width_p-1:0]       exe_pc,
  input  logic                          flush,
  input  logic                          branch_mispredict,
  input  logic                          jalr_mispredict,
  input  logic                          icache_miss,
  input  logic                          icache_miss_in_pipe,
  input  logic                          stall_all,
  input  logic                          stall_id,
  input  logic                          stall_depend_long_op,
  input  logic                          stall_depend_local_load,
  input  logic                          stall_depend_imul,
  input  logic                          stall_bypass,
  input  logic                          stall_lr_aq,
  input  logic                          stall_fence,
  input  logic                          stall_amo_aq,
  input  logic                          stall_amo_rl,
  input  logic                          stall_fdiv_busy,
  input  logic                          stall_idiv_busy,
  input  logic                          stall_fcsr,
  input  logic                          stall_remote_req,
  input  logic                          stall_remote_credit,
  input  logic                          stall_barrier,
  input  logic                          stall_icache_store,
  input  logic                          stall_remote_ld_wb,
  input  logic                          stall_ifetch_wait,
  input  logic                          stall_remote_flw_wb,
  input  logic [data_width_p-1:0]       rs1_val_to_exe,
  input  logic [RV32_Iimm_width_gp-1:0] mem_addr_op2,
  input  logic                          int_sb_clear,
  input  logic                          float_sb_clear,
  input  logic [4:0]                    int_sb_clear_id,
  input  logic [4:0]                    float_sb_clear_id,
  input  id_signals_s                   id_r,
  input  exe_signals_s                  exe_r,
  input  fp_exe_ctrl_signals_s          fp_exe_ctrl_r,
  input  logic [x_cord_width_p-1:0]     global_x_i,
  input  logic [y_cord_width_p-1:0]     global_y_i,
  output exe_bubble_type_e              exe_bubble_type_o,
  output logic [pc_width_p-1:0]         exe_bubble_pc_o
);

  decode_s d;
  assign d = id_r.decode;

  logic unused;
  assign unused = ^{pc_r, pc_n, if_pc, icache_miss, icache_miss_in_pipe, stall_icache_store,
                    stall_remote_ld_wb, stall_ifetch_wait, stall_remote_flw_wb, exe_r,
                    fp_exe_ctrl_r};

  // Remote address classification of the instruction leaving ID.
  logic [data_width_p-1:0] mem_addr;
  assign mem_addr = rs1_val_to_exe
                  + {{(data_width_p-RV32_Iimm_width_gp){mem_addr_op2[RV32_Iimm_width_gp-1]}},
                     mem_addr_op2};

  logic [x_cord_width_p-1:0] rel_x;
  logic [y_cord_width_p-1:0] rel_y;
  logic [x_cord_width_p:0]   sum_x;
  logic [y_cord_width_p:0]   sum_y;
  logic                      group_overflow;
  assign rel_x = global_x_i - x_cord_width_p'(origin_x_cord_p);
  assign rel_y = global_y_i - y_cord_width_p'(origin_y_cord_p);
  assign sum_x = {1'b0, rel_x} + {1'b0, mem_addr[18 +: x_cord_width_p]};
  assign sum_y = {1'b0, rel_y} + {1'b0, mem_addr[24 +: y_cord_width_p]};
  assign group_overflow = sum_x[x_cord_width_p] | sum_y[y_cord_width_p];

  logic unused_addr;
  assign unused_addr = ^{mem_addr, sum_x, sum_y};

  sb_class_e remote_class;
  always_comb begin
    // NOTE: default first so every path assigns remote_class and no latch is inferred.
    remote_class = e_sb_none;
    if (mem_addr[31])
      remote_class = d.is_amo_op ? e_sb_dram_amo : e_sb_dram;
    else if (mem_addr[31:30] == 2'b01)
      remote_class = e_sb_global;
    else if (mem_addr[31:29] == 3'b001)
      remote_class = group_overflow ? e_sb_group_overflow
                   : (d.is_amo_op ? e_sb_group_amo : e_sb_group);
  end

  logic issue, remote_mem;
  assign issue      = ~stall_all & ~stall_id & ~flush;
  assign remote_mem = (d.is_load_op | d.is_amo_op) & (remote_class != e_sb_none);

  logic      int_set, fp_set;
  sb_class_e int_set_class, fp_set_class;
  assign int_set       = issue & d.write_rd & (id_r.rd != 5'd0) & (remote_mem | d.is_idiv_op);
  assign int_set_class = remote_mem ? remote_class : e_sb_idiv;
  assign fp_set        = issue & d.write_frd & (remote_mem | d.is_fp_div_op);
  assign fp_set_class  = remote_mem ? remote_class : e_sb_fdiv;

  logic [4:0] int_read_id [3];
  logic [4:0] fp_read_id  [4];
  sb_class_e  int_class   [3];
  sb_class_e  fp_class    [4];
  assign int_read_id = '{id_r.rs1, id_r.rs2, id_r.rd};
  assign fp_read_id  = '{id_r.rs1, id_r.rs2, id_r.rs3, id_r.rd};

  vanilla_bubble_scoreboard sb (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .int_set        (int_set),
    .int_set_id     (id_r.rd),
    .int_set_class  (int_set_class),
    .fp_set         (fp_set),
    .fp_set_id      (id_r.rd),
    .fp_set_class   (fp_set_class),
    .int_clear      (int_sb_clear),
    .int_clear_id   (int_sb_clear_id),
    .fp_clear       (float_sb_clear),
    .fp_clear_id    (float_sb_clear_id),
    .int_read_id    (int_read_id),
    .int_read_class (int_class),
    .fp_read_id     (fp_read_id),
    .fp_read_class  (fp_class)
  );

  // Candidates in blame order: rs1, rs2, rd, frs1, frs2, frs3, frd.
  logic [6:0] cand_used;
  sb_class_e  long_op_class;
  always_comb begin
    cand_used = {d.write_frd, d.read_frs3, d.read_frs2, d.read_frs1,
                 d.write_rd, d.read_rs2, d.read_rs1};
    long_op_class = e_sb_none;
    for (int i = 6; i >= 0; i--) begin
      if (i < 3) begin
        if (cand_used[i] && int_class[i] != e_sb_none) long_op_class = int_class[i];
      end else begin
        if (cand_used[i] && fp_class[i-3] != e_sb_none) long_op_class = fp_class[i-3];
      end
    end
  end

  exe_bubble_type_e stall_type;
  always_comb begin
    stall_type = e_exe_bubble_stall_bypass;
    if      (stall_depend_long_op)    stall_type = class_to_bubble(long_op_class);
    else if (stall_depend_local_load) stall_type = e_exe_bubble_stall_depend_local_load;
    else if (stall_depend_imul)       stall_type = e_exe_bubble_stall_depend_imul;
    else if (stall_bypass)            stall_type = e_exe_bubble_stall_bypass;
    else if (stall_lr_aq)             stall_type = e_exe_bubble_stall_lr_aq;
    else if (stall_fence)             stall_type = e_exe_bubble_stall_fence;
    else if (stall_amo_aq)            stall_type = e_exe_bubble_stall_amo_aq;
    else if (stall_amo_rl)            stall_type = e_exe_bubble_stall_amo_rl;
    else if (stall_fdiv_busy)         stall_type = e_exe_bubble_stall_fdiv_busy;
    else if (stall_idiv_busy)         stall_type = e_exe_bubble_stall_idiv_busy;
    else if (stall_fcsr)              stall_type = e_exe_bubble_stall_fcsr;
    else if (stall_remote_req)        stall_type = e_exe_bubble_stall_remote_req;
    else if (stall_remote_credit)     stall_type = e_exe_bubble_stall_remote_credit;
    else if (stall_barrier)           stall_type = e_exe_bubble_stall_barrier;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exe_bubble_type_o <= e_exe_no_bubble;
      exe_bubble_pc_o   <= '0;
    end else if (!stall_all) begin
      if (branch_mispredict) begin
        exe_bubble_type_o <= e_exe_bubble_branch_miss;
        exe_bubble_pc_o   <= exe_pc[pc_width_p-1:0];
      end else if (jalr_mispredict) begin
        exe_bubble_type_o <= e_exe_bubble_jalr_miss;
        exe_bubble_pc_o   <= exe_pc[pc_width_p-1:0];
      end else if (id_r.icache_miss) begin
        exe_bubble_type_o <= e_exe_bubble_icache_miss;
        exe_bubble_pc_o   <= id_pc[pc_width_p-1:0];
      end else if (stall_id) begin
        exe_bubble_type_o <= stall_type;
        exe_bubble_pc_o   <= id_pc[pc_width_p-1:0];
      end else begin
        exe_bubble_type_o <= e_exe_no_bubble;
        exe_bubble_pc_o   <= exe_pc[pc_width_p-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vanilla_exe_bubble_classifier.sv
// Self-checking bench: directed scenarios plus random traffic against a
// rule-level reference model of the bubble classifier.
module tb_vanilla_exe_bubble_classifier;
  import vanilla_exe_bubble_classifier_pkg::*;

  localparam int XW = 4;
  localparam int YW = 3;
  localparam int OX = 0;
  localparam int OY = 0;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i;
  logic [31:0] pc_r, pc_n, if_pc, id_pc, exe_pc;
  logic        flush, branch_mispredict, jalr_mispredict, icache_miss, icache_miss_in_pipe;
  logic        stall_all, stall_id;
  logic        stall_depend_long_op, stall_depend_local_load, stall_depend_imul, stall_bypass;
  logic        stall_lr_aq, stall_fence, stall_amo_aq, stall_amo_rl, stall_fdiv_busy;
  logic        stall_idiv_busy, stall_fcsr, stall_remote_req, stall_remote_credit, stall_barrier;
  logic        stall_icache_store, stall_remote_ld_wb, stall_ifetch_wait, stall_remote_flw_wb;
  logic [31:0] rs1_val_to_exe;
  logic [11:0] mem_addr_op2;
  logic        int_sb_clear, float_sb_clear;
  logic [4:0]  int_sb_clear_id, float_sb_clear_id;
  id_signals_s          id_r;
  exe_signals_s         exe_r;
  fp_exe_ctrl_signals_s fp_exe_ctrl_r;
  logic [XW-1:0] global_x_i;
  logic [YW-1:0] global_y_i;
  exe_bubble_type_e exe_bubble_type_o;
  logic [31:0]      exe_bubble_pc_o;

  vanilla_exe_bubble_classifier #(
    .pc_width_p(32), .data_width_p(32), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .origin_x_cord_p(OX), .origin_y_cord_p(OY)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_r(pc_r), .pc_n(pc_n),
    .if_pc(if_pc), .id_pc(id_pc), .exe_pc(exe_pc), .flush(flush),
    .branch_mispredict(branch_mispredict), .jalr_mispredict(jalr_mispredict),
    .icache_miss(icache_miss), .icache_miss_in_pipe(icache_miss_in_pipe),
    .stall_all(stall_all), .stall_id(stall_id),
    .stall_depend_long_op(stall_depend_long_op), .stall_depend_local_load(stall_depend_local_load),
    .stall_depend_imul(stall_depend_imul), .stall_bypass(stall_bypass), .stall_lr_aq(stall_lr_aq),
    .stall_fence(stall_fence), .stall_amo_aq(stall_amo_aq), .stall_amo_rl(stall_amo_rl),
    .stall_fdiv_busy(stall_fdiv_busy), .stall_idiv_busy(stall_idiv_busy), .stall_fcsr(stall_fcsr),
    .stall_remote_req(stall_remote_req), .stall_remote_credit(stall_remote_credit),
    .stall_barrier(stall_barrier), .stall_icache_store(stall_icache_store),
    .stall_remote_ld_wb(stall_remote_ld_wb), .stall_ifetch_wait(stall_ifetch_wait),
    .stall_remote_flw_wb(stall_remote_flw_wb), .rs1_val_to_exe(rs1_val_to_exe),
    .mem_addr_op2(mem_addr_op2), .int_sb_clear(int_sb_clear), .float_sb_clear(float_sb_clear),
    .int_sb_clear_id(int_sb_clear_id), .float_sb_clear_id(float_sb_clear_id),
    .id_r(id_r), .exe_r(exe_r), .fp_exe_ctrl_r(fp_exe_ctrl_r),
    .global_x_i(global_x_i), .global_y_i(global_y_i),
    .exe_bubble_type_o(exe_bubble_type_o), .exe_bubble_pc_o(exe_bubble_pc_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: class owning each pending register, and the expected outputs.
  sb_class_e        m_int [32];
  sb_class_e        m_fp  [32];
  exe_bubble_type_e exp_type;
  logic [31:0]      exp_pc;

  function automatic sb_class_e addr_class(logic [31:0] a, bit amo);
    int unsigned ua = a;
    int xs = ((int'(global_x_i) - OX + 16) % 16) + int'((ua >> 18) % 16);
    int ys = ((int'(global_y_i) - OY + 8) % 8) + int'((ua >> 24) % 8);
    if (ua >= 32'h8000_0000) return amo ? e_sb_dram_amo : e_sb_dram;
    if (ua >= 32'h4000_0000) return e_sb_global;
    if (ua >= 32'h2000_0000) begin
      if (xs >= 16 || ys >= 8) return e_sb_group_overflow;
      return amo ? e_sb_group_amo : e_sb_group;
    end
    return e_sb_none;
  endfunction

  function automatic exe_bubble_type_e blame_long_op();
    sb_class_e c = e_sb_none;
    sb_class_e q[$];
    if (id_r.decode.read_rs1)  q.push_back(m_int[id_r.rs1]);
    if (id_r.decode.read_rs2)  q.push_back(m_int[id_r.rs2]);
    if (id_r.decode.write_rd)  q.push_back(m_int[id_r.rd]);
    if (id_r.decode.read_frs1) q.push_back(m_fp[id_r.rs1]);
    if (id_r.decode.read_frs2) q.push_back(m_fp[id_r.rs2]);
    if (id_r.decode.read_frs3) q.push_back(m_fp[id_r.rs3]);
    if (id_r.decode.write_frd) q.push_back(m_fp[id_r.rd]);
    foreach (q[i]) if (c == e_sb_none) c = q[i];
    case (c)
      e_sb_dram:           return e_exe_bubble_stall_depend_dram;
      e_sb_dram_amo:       return e_exe_bubble_stall_depend_dram_amo;
      e_sb_group:          return e_exe_bubble_stall_depend_group;
      e_sb_group_amo:      return e_exe_bubble_stall_depend_group_amo;
      e_sb_group_overflow: return e_exe_bubble_stall_depend_group_overflow;
      e_sb_idiv:           return e_exe_bubble_stall_depend_idiv;
      e_sb_fdiv:           return e_exe_bubble_stall_depend_fdiv;
      default:             return e_exe_bubble_stall_depend_global;
    endcase
  endfunction

  function automatic exe_bubble_type_e stall_cause();
    bit flags [14] = '{stall_depend_long_op, stall_depend_local_load, stall_depend_imul,
                       stall_bypass, stall_lr_aq, stall_fence, stall_amo_aq, stall_amo_rl,
                       stall_fdiv_busy, stall_idiv_busy, stall_fcsr, stall_remote_req,
                       stall_remote_credit, stall_barrier};
    exe_bubble_type_e names [14] = '{e_exe_bubble_stall_depend_global,
      e_exe_bubble_stall_depend_local_load, e_exe_bubble_stall_depend_imul,
      e_exe_bubble_stall_bypass, e_exe_bubble_stall_lr_aq, e_exe_bubble_stall_fence,
      e_exe_bubble_stall_amo_aq, e_exe_bubble_stall_amo_rl, e_exe_bubble_stall_fdiv_busy,
      e_exe_bubble_stall_idiv_busy, e_exe_bubble_stall_fcsr, e_exe_bubble_stall_remote_req,
      e_exe_bubble_stall_remote_credit, e_exe_bubble_stall_barrier};
    if (flags[0]) return blame_long_op();
    for (int i = 1; i < 14; i++) if (flags[i]) return names[i];
    return e_exe_bubble_stall_bypass;
  endfunction

  // Predict from the inputs present before the edge, then advance one clock.
  task automatic tick();
    logic [31:0] addr;
    sb_class_e   c;
    if (reset_i) begin
      foreach (m_int[i]) begin m_int[i] = e_sb_none; m_fp[i] = e_sb_none; end
      exp_type = e_exe_no_bubble;
      exp_pc   = 32'h0;
    end else begin
      if (!stall_all) begin
        if (branch_mispredict)    begin exp_type = e_exe_bubble_branch_miss; exp_pc = exe_pc; end
        else if (jalr_mispredict) begin exp_type = e_exe_bubble_jalr_miss;   exp_pc = exe_pc; end
        else if (id_r.icache_miss) begin exp_type = e_exe_bubble_icache_miss; exp_pc = id_pc; end
        else if (stall_id)        begin exp_type = stall_cause();            exp_pc = id_pc; end
        else                      begin exp_type = e_exe_no_bubble;          exp_pc = exe_pc; end
      end
      if (int_sb_clear)   m_int[int_sb_clear_id]  = e_sb_none;
      if (float_sb_clear) m_fp[float_sb_clear_id] = e_sb_none;
      if (!stall_all && !stall_id && !flush) begin
        addr = rs1_val_to_exe + 32'($signed(mem_addr_op2));
        c = addr_class(addr, id_r.decode.is_amo_op);
        if ((id_r.decode.is_load_op || id_r.decode.is_amo_op) && c != e_sb_none) begin
          if (id_r.decode.write_rd && id_r.rd != 0) m_int[id_r.rd] = c;
          if (id_r.decode.write_frd)                m_fp[id_r.rd]  = c;
        end
        if (id_r.decode.is_idiv_op && id_r.decode.write_rd && id_r.rd != 0) m_int[id_r.rd] = e_sb_idiv;
        if (id_r.decode.is_fp_div_op && id_r.decode.write_frd) m_fp[id_r.rd] = e_sb_fdiv;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    {pc_r, pc_n, if_pc} = '0;
    id_pc = 32'h0; exe_pc = 32'h0;
    {flush, branch_mispredict, jalr_mispredict, icache_miss, icache_miss_in_pipe} = '0;
    {stall_all, stall_id, stall_depend_long_op, stall_depend_local_load, stall_depend_imul} = '0;
    {stall_bypass, stall_lr_aq, stall_fence, stall_amo_aq, stall_amo_rl, stall_fdiv_busy} = '0;
    {stall_idiv_busy, stall_fcsr, stall_remote_req, stall_remote_credit, stall_barrier} = '0;
    {stall_icache_store, stall_remote_ld_wb, stall_ifetch_wait, stall_remote_flw_wb} = '0;
    rs1_val_to_exe = 32'h0; mem_addr_op2 = 12'h0;
    {int_sb_clear, float_sb_clear, int_sb_clear_id, float_sb_clear_id} = '0;
    id_r = '0; exe_r = '0; fp_exe_ctrl_r = '0;
    global_x_i = 4'd2; global_y_i = 3'd1;
  endtask

  task automatic issue_load(logic [4:0] rd, logic [31:0] base, logic [11:0] imm, bit amo);
    idle_inputs();
    id_r.decode.is_load_op = !amo;
    id_r.decode.is_amo_op  = amo;
    id_r.decode.write_rd   = 1'b1;
    id_r.rd = rd; rs1_val_to_exe = base; mem_addr_op2 = imm;
  endtask

  task automatic dep_stall(logic [4:0] rs1, logic [31:0] pc);
    idle_inputs();
    stall_id = 1'b1; stall_depend_long_op = 1'b1;
    id_r.decode.read_rs1 = 1'b1; id_r.rs1 = rs1; id_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    exe_pc = 32'h0000_0abc;
    reset_i = 1'b1;
    tick(); tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_no_bubble, 32'h0}) begin
      bad++; $display("FAIL reset: got %s pc=%h want e_exe_no_bubble pc=0", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    reset_i = 1'b0;
    idle_inputs(); exe_pc = 32'h100;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {exp_type, exp_pc}) begin
      bad++; $display("FAIL idle: got %s pc=%h want %s pc=%h", exe_bubble_type_o.name(), exe_bubble_pc_o, exp_type.name(), exp_pc);
    end
    total++;
  endtask

  task automatic test_redirect();
    idle_inputs(); branch_mispredict = 1'b1; exe_pc = 32'h200;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_branch_miss, 32'h200}) begin
      bad++; $display("FAIL branch: got %s pc=%h want branch_miss pc=200", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    idle_inputs(); stall_all = 1'b1; exe_pc = 32'h300; jalr_mispredict = 1'b1;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_branch_miss, 32'h200}) begin
      bad++; $display("FAIL stall_all_hold: got %s pc=%h want branch_miss pc=200", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    idle_inputs(); jalr_mispredict = 1'b1; exe_pc = 32'h204; id_r.icache_miss = 1'b1; id_pc = 32'h208;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_jalr_miss, 32'h204}) begin
      bad++; $display("FAIL jalr: got %s pc=%h want jalr_miss pc=204", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    idle_inputs(); id_r.icache_miss = 1'b1; id_pc = 32'h208; stall_id = 1'b1; stall_fence = 1'b1;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_icache_miss, 32'h208}) begin
      bad++; $display("FAIL icache: got %s pc=%h want icache_miss pc=208", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
  endtask

  task automatic test_dram_dep();
    issue_load(5'd5, 32'h8000_0000, 12'h010, 1'b0); exe_pc = 32'h100;
    tick();
    dep_stall(5'd5, 32'h304);
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_stall_depend_dram, 32'h304}) begin
      bad++; $display("FAIL dram_dep: got %s pc=%h want stall_depend_dram pc=304", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    idle_inputs(); int_sb_clear = 1'b1; int_sb_clear_id = 5'd5;
    tick();
    dep_stall(5'd5, 32'h304);
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_stall_depend_global, 32'h304}) begin
      bad++; $display("FAIL cleared_dep: got %s pc=%h want stall_depend_global pc=304", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
  endtask

  task automatic test_regions();
    logic [31:0]      bases [3] = '{32'h4000_0000, 32'h2000_0000, 32'h2003_FFFC};
    logic [11:0]      imms  [3] = '{12'h000, 12'h000, 12'h004};
    exe_bubble_type_e want  [3] = '{e_exe_bubble_stall_depend_global, e_exe_bubble_stall_depend_group,
                                    e_exe_bubble_stall_depend_group_overflow};
    for (int i = 0; i < 3; i++) begin
      issue_load(5'(10 + i), bases[i], imms[i], 1'b0);
      if (i == 2) global_x_i = 4'(OX + 15);
      tick();
      dep_stall(5'(10 + i), 32'h400 + 32'(i));
      tick();
      if ({exe_bubble_type_o, exe_bubble_pc_o} !== {want[i], 32'h400 + 32'(i)}) begin
        bad++; $display("FAIL region[%0d]: got %s pc=%h want %s", i, exe_bubble_type_o.name(), exe_bubble_pc_o, want[i].name());
      end
      total++;
    end
    // Local address is not recorded.
    issue_load(5'd13, 32'h0000_1000, 12'h000, 1'b0);
    tick();
    dep_stall(5'd13, 32'h410);
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_depend_global) begin
      bad++; $display("FAIL local_load: got %s want stall_depend_global", exe_bubble_type_o.name());
    end
    total++;
  endtask

  task automatic test_stall_causes();
    idle_inputs(); stall_id = 1'b1; stall_fence = 1'b1; stall_remote_credit = 1'b1; id_pc = 32'h500;
    tick();
    if ({exe_bubble_type_o, exe_bubble_pc_o} !== {e_exe_bubble_stall_fence, 32'h500}) begin
      bad++; $display("FAIL fence_prio: got %s pc=%h want stall_fence pc=500", exe_bubble_type_o.name(), exe_bubble_pc_o);
    end
    total++;
    idle_inputs(); stall_id = 1'b1; stall_barrier = 1'b1; id_pc = 32'h504;
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_barrier) begin
      bad++; $display("FAIL barrier: got %s want stall_barrier", exe_bubble_type_o.name());
    end
    total++;
    idle_inputs(); stall_id = 1'b1; id_pc = 32'h508;
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_bypass) begin
      bad++; $display("FAIL no_cause: got %s want stall_bypass", exe_bubble_type_o.name());
    end
    total++;
  endtask

  task automatic test_set_wins();
    issue_load(5'd7, 32'h2000_0000, 12'h000, 1'b0);
    tick();
    issue_load(5'd7, 32'h8000_0000, 12'h020, 1'b1);
    int_sb_clear = 1'b1; int_sb_clear_id = 5'd7;
    tick();
    dep_stall(5'd7, 32'h600);
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_depend_dram_amo) begin
      bad++; $display("FAIL set_wins: got %s want stall_depend_dram_amo", exe_bubble_type_o.name());
    end
    total++;
  endtask

  task automatic test_div_fp();
    idle_inputs(); id_r.decode.is_fp_div_op = 1'b1; id_r.decode.write_frd = 1'b1; id_r.rd = 5'd0;
    tick();
    idle_inputs(); id_r.decode.is_idiv_op = 1'b1; id_r.decode.write_rd = 1'b1; id_r.rd = 5'd9;
    tick();
    idle_inputs(); stall_id = 1'b1; stall_depend_long_op = 1'b1;
    id_r.decode.read_frs2 = 1'b1; id_r.decode.read_rs1 = 1'b1; id_r.rs1 = 5'd9; id_r.rs2 = 5'd0;
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_depend_idiv) begin
      bad++; $display("FAIL idiv_first: got %s want stall_depend_idiv", exe_bubble_type_o.name());
    end
    total++;
    idle_inputs(); stall_id = 1'b1; stall_depend_long_op = 1'b1;
    id_r.decode.read_frs2 = 1'b1; id_r.rs2 = 5'd0;
    tick();
    if (exe_bubble_type_o !== e_exe_bubble_stall_depend_fdiv) begin
      bad++; $display("FAIL fdiv_f0: got %s want stall_depend_fdiv", exe_bubble_type_o.name());
    end
    total++;
  endtask

  task automatic test_random();
    logic [31:0] regions [4] = '{32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      exe_pc = $urandom; id_pc = $urandom;
      stall_all         = ($urandom_range(0, 9) == 0);
      stall_id          = ($urandom_range(0, 9) < 4);
      flush             = ($urandom_range(0, 9) == 0);
      branch_mispredict = ($urandom_range(0, 19) == 0);
      jalr_mispredict   = ($urandom_range(0, 19) == 0);
      id_r.icache_miss  = ($urandom_range(0, 19) == 0);
      stall_depend_long_op = ($urandom_range(0, 1) == 0);
      {stall_depend_local_load, stall_depend_imul, stall_bypass, stall_lr_aq, stall_fence,
       stall_amo_aq, stall_amo_rl, stall_fdiv_busy, stall_idiv_busy, stall_fcsr,
       stall_remote_req, stall_remote_credit, stall_barrier} = 13'($urandom) & 13'($urandom);
      id_r.rs1 = 5'($urandom_range(0, 7)); id_r.rs2 = 5'($urandom_range(0, 7));
      id_r.rs3 = 5'($urandom_range(0, 7)); id_r.rd  = 5'($urandom_range(0, 7));
      {id_r.decode.read_rs1, id_r.decode.read_rs2, id_r.decode.read_frs1,
       id_r.decode.read_frs2, id_r.decode.read_frs3, id_r.decode.write_rd,
       id_r.decode.write_frd} = 7'($urandom);
      case ($urandom_range(0, 4))
        0: id_r.decode.is_load_op   = 1'b1;
        1: id_r.decode.is_amo_op    = 1'b1;
        2: id_r.decode.is_idiv_op   = 1'b1;
        3: id_r.decode.is_fp_div_op = 1'b1;
        default: ;
      endcase
      rs1_val_to_exe = regions[$urandom_range(0, 3)] | ($urandom & 32'h1FFF_FFFF);
      mem_addr_op2   = 12'($urandom);
      global_x_i = 4'($urandom); global_y_i = 3'($urandom);
      int_sb_clear = ($urandom_range(0, 3) == 0); int_sb_clear_id = 5'($urandom_range(0, 7));
      float_sb_clear = ($urandom_range(0, 3) == 0); float_sb_clear_id = 5'($urandom_range(0, 7));
      tick();
      if ({exe_bubble_type_o, exe_bubble_pc_o} !== {exp_type, exp_pc}) begin
        bad++; $display("FAIL random[%0d]: got %s pc=%h want %s pc=%h", n, exe_bubble_type_o.name(), exe_bubble_pc_o, exp_type.name(), exp_pc);
      end
      total++;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_redirect();
    test_dram_dep();
    test_regions();
    test_stall_causes();
    test_set_wins();
    test_div_fp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
